apb_multi_slave_master: RTL and testbench

- Parametrised APB master bridge: takes single-transaction read/write commands over a valid/ready interface and runs them as APB3/APB4 transfers to one of NUM_SLAVES slaves, decoded from upper address bits.
- Adds wait-state timeout, decode-error detection, byte strobes and a held response channel.
- Sits between the UART/GPIO control logic (or a test driver) and the APB slave fabric.

---
 rtl/apb_multi_slave_master.sv | 130 +++++++++++++
 tb/tb_apb_multi_slave_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_slave_master.sv
// apb_multi_slave_master: valid/ready command to APB3/APB4 master bridge with slave decode, timeout and held response.
module apb_multi_slave_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic [DATA_W/8-1:0]          cmd_strb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [1:0]                   rsp_code,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [1:0] RC_OK = 2'd0, RC_SLVERR = 2'd1, RC_TIMEOUT = 2'd2, RC_DECERR = 2'd3;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                write_q, write_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          code_q, code_d;
  logic [SEL_W-1:0]    cmd_idx;
  logic [2**SEL_W-1:0] slv_ok;
  logic [DATA_W-1:0]   prd [NUM_SLAVES];
  logic                to_hit;
  assign cmd_idx = cmd_addr[ADDR_W-1 -: SEL_W];
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_ok
    assign slv_ok[i] = (i < NUM_SLAVES);
  end
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_prd
    assign prd[i] = PRDATA[i*DATA_W +: DATA_W];
  end
  // Counter holds completed wait cycles; the TIMEOUT-th wait cycle ends the access.
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_code  = code_q;
  assign rsp_err   = (code_q != RC_OK);
  assign PSEL      = (state_q == SETUP || state_q == ACCESS) ? NUM_SLAVES'(1) << idx_q : '0;
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = write_q;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = write_q ? strb_q : '0;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        strb_d  = cmd_strb;
        write_d = cmd_write;
        idx_d   = cmd_idx;
        cnt_d   = '0;
        rdata_d = '0;
        code_d  = slv_ok[cmd_idx] ? RC_OK : RC_DECERR;
        state_d = slv_ok[cmd_idx] ? SETUP : RESP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (PREADY[idx_q]) begin
        rdata_d = (!write_q && !PSLVERR[idx_q]) ? prd[idx_q] : '0;
        code_d  = PSLVERR[idx_q] ? RC_SLVERR : RC_OK;
        state_d = RESP;
      end else if (to_hit) begin
        rdata_d = '0;
        code_d  = RC_TIMEOUT;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      code_q  <= RC_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
    end
  end
endmodule

// File: tb/tb_apb_multi_slave_master.sv
// tb_apb_multi_slave_master: randomized bench with behavioural APB slaves and a response model for a 3-slave bridge.
module tb_apb_multi_slave_master;
  localparam int AW = 32, DW = 32, NS = 3, SW = 2, TO = 16, SBW = DW / 8;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SBW-1:0] cmd_strb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_code;
  logic [NS-1:0] PSEL, PREADY, PSLVERR;
  logic PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SBW-1:0] PSTRB;
  logic [NS*DW-1:0] PRDATA;
  int checks = 0, passed = 0;
  int wait_cfg [NS];
  logic err_cfg [NS];
  logic [DW-1:0] data_cfg [NS];
  logic [5:0] noise = '0;
  always #5 PCLK = ~PCLK;
  always @(negedge PCLK) noise <= 6'($urandom);
  apb_multi_slave_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_code(rsp_code), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  // Each slave answers after wait_cfg ACCESS cycles; unselected slaves drive noise.
  for (genvar k = 0; k < NS; k++) begin : g_slv
    int acc = 0;
    always @(posedge PCLK) acc <= (PSEL[k] && PENABLE) ? acc + 1 : 0;
    assign PRDATA[k*DW +: DW] = data_cfg[k];
    assign PREADY[k]  = (PSEL[k] && PENABLE) ? (acc == wait_cfg[k]) : noise[k];
    assign PSLVERR[k] = PSEL[k] ? err_cfg[k] : noise[k+3];
  end
  // Starts and ends on a negedge with the bridge idle.
  task automatic do_txn(input logic wr, input logic [1:0] idx, input logic [29:0] low,
                        input logic [31:0] wd, input logic [3:0] sb, input int hold, input string name);
    logic [1:0] ecode, c0;
    logic [31:0] erd, r0, c_addr, c_wd;
    logic [3:0] c_sb;
    logic [2:0] eoh;
    logic c_wr, c_pen, sel_bad, unstable, hold_bad;
    int eacc, elat, lat, psel_n, pen_n;
    if (int'(idx) >= NS) begin
      ecode = 2'd3; erd = '0; eacc = 0; elat = 1;
    end else if (wait_cfg[int'(idx)] >= TO) begin
      ecode = 2'd2; erd = '0; eacc = TO; elat = 2 + TO;
    end else begin
      ecode = err_cfg[int'(idx)] ? 2'd1 : 2'd0;
      erd = (!wr && !err_cfg[int'(idx)]) ? data_cfg[int'(idx)] : '0;
      eacc = wait_cfg[int'(idx)] + 1; elat = 2 + eacc;
    end
    eoh = (int'(idx) < NS) ? 3'(1 << idx) : 3'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = {idx, low}; cmd_wdata = wd; cmd_strb = sb;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready: got %b exp 1", name, cmd_ready); else passed++;
    lat = 0; psel_n = 0; pen_n = 0; sel_bad = 0; unstable = 0;
    c_addr = '0; c_wd = '0; c_sb = '0; c_wr = 0; c_pen = 0;
    while (lat < 60) begin
      @(negedge PCLK);
      lat++;
      if (lat == 1) begin
        cmd_valid = 1'b0;
        c_addr = PADDR; c_wd = PWDATA; c_sb = PSTRB; c_wr = PWRITE; c_pen = PENABLE;
      end
      if (rsp_valid) break;
      if (PSEL != 0) psel_n++;
      if (PENABLE) pen_n++;
      if (PSEL !== 3'b0 && PSEL !== eoh) sel_bad = 1;
      if (PSEL != 0 && (PADDR !== c_addr || PWDATA !== c_wd || PSTRB !== c_sb || PWRITE !== c_wr)) unstable = 1;
    end
    checks++; if (!rsp_valid || lat != elat) $display("FAIL %s latency: got %0d (valid %b) exp %0d", name, lat, rsp_valid, elat); else passed++;
    checks++; if (rsp_code !== ecode) $display("FAIL %s rsp_code: got %0d exp %0d", name, rsp_code, ecode); else passed++;
    checks++; if (rsp_err !== (ecode != 0)) $display("FAIL %s rsp_err: got %b exp %b", name, rsp_err, ecode != 0); else passed++;
    checks++; if (rsp_rdata !== erd) $display("FAIL %s rsp_rdata: got %h exp %h", name, rsp_rdata, erd); else passed++;
    checks++; if (psel_n != ((int'(idx) < NS) ? eacc + 1 : 0)) $display("FAIL %s psel_cycles: got %0d exp %0d", name, psel_n, (int'(idx) < NS) ? eacc + 1 : 0); else passed++;
    checks++; if (pen_n != eacc) $display("FAIL %s penable_cycles: got %0d exp %0d", name, pen_n, eacc); else passed++;
    checks++; if (sel_bad) $display("FAIL %s psel_onehot: got bad select exp %b", name, eoh); else passed++;
    checks++; if (unstable) $display("FAIL %s apb_stable: got change during transfer exp stable", name); else passed++;
    if (int'(idx) < NS) begin
      checks++; if (c_addr !== {idx, low}) $display("FAIL %s paddr: got %h exp %h", name, c_addr, {idx, low}); else passed++;
      checks++; if (c_wr !== wr) $display("FAIL %s pwrite: got %b exp %b", name, c_wr, wr); else passed++;
      checks++; if (c_wd !== wd) $display("FAIL %s pwdata: got %h exp %h", name, c_wd, wd); else passed++;
      checks++; if (c_sb !== (wr ? sb : 4'h0)) $display("FAIL %s pstrb: got %h exp %h", name, c_sb, wr ? sb : 4'h0); else passed++;
      checks++; if (c_pen !== 1'b0) $display("FAIL %s setup_penable: got %b exp 0", name, c_pen); else passed++;
    end
    r0 = rsp_rdata; c0 = rsp_code; hold_bad = 0;
    rsp_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge PCLK);
      if (!rsp_valid || cmd_ready || PSEL != 0 || PENABLE || rsp_rdata !== r0 || rsp_code !== c0) hold_bad = 1;
    end
    checks++; if (hold_bad) $display("FAIL %s rsp_hold: got response change over %0d cycles exp held", name, hold); else passed++;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL %s back_to_idle: got ready %b valid %b exp 1 0", name, cmd_ready, rsp_valid); else passed++;
  endtask
  task automatic set_slave(input int s, input int w, input logic e, input logic [31:0] d);
    wait_cfg[s] = w; err_cfg[s] = e; data_cfg[s] = d;
  endtask
  task automatic test_reset;
    #1 PRESETn = 1'b0;
    #2;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL reset handshake: got ready %b valid %b exp 1 0", cmd_ready, rsp_valid); else passed++;
    checks++; if (PSEL !== 3'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) $display("FAIL reset apb_ctrl: got psel %b en %b wr %b exp 0", PSEL, PENABLE, PWRITE); else passed++;
    checks++; if (PADDR !== '0 || PWDATA !== '0 || PSTRB !== '0) $display("FAIL reset apb_data: got %h %h %h exp 0", PADDR, PWDATA, PSTRB); else passed++;
    checks++; if (rsp_rdata !== '0 || rsp_code !== 2'd0 || rsp_err !== 1'b0) $display("FAIL reset rsp: got %h %0d %b exp 0", rsp_rdata, rsp_code, rsp_err); else passed++;
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask
  task automatic test_zero_wait_write;
    set_slave(0, 0, 1'b0, 32'hDEAD_0000);
    do_txn(1'b1, 2'd0, 30'h10, 32'hA5A5_0001, 4'hF, 0, "zero_wait_write");
  endtask
  task automatic test_wait_read;
    set_slave(1, 3, 1'b0, 32'h1234_5678);
    do_txn(1'b0, 2'd1, 30'h4, 32'h0BAD_F00D, 4'h5, 0, "wait_read");
  endtask
  task automatic test_slverr;
    set_slave(2, 0, 1'b1, 32'h7777_7777);
    do_txn(1'b1, 2'd2, 30'h20, 32'hCAFE_0002, 4'h3, 0, "slverr_write");
    do_txn(1'b0, 2'd2, 30'h24, 32'h0, 4'h0, 0, "slverr_read");
    err_cfg[2] = 1'b0;
  endtask
  task automatic test_timeout;
    set_slave(0, 1000, 1'b0, 32'h5555_AAAA);
    do_txn(1'b0, 2'd0, 30'h30, 32'h0, 4'h0, 0, "timeout_read");
    set_slave(0, TO - 1, 1'b0, 32'h5555_AAAA);
    do_txn(1'b0, 2'd0, 30'h34, 32'h0, 4'h0, 0, "ready_at_limit");
    set_slave(0, TO, 1'b0, 32'h5555_AAAA);
    do_txn(1'b1, 2'd0, 30'h38, 32'h1111_2222, 4'hC, 0, "ready_past_limit");
  endtask
  task automatic test_decerr;
    do_txn(1'b0, 2'd3, 30'h0, 32'h0, 4'h0, 0, "decerr_read");
    do_txn(1'b1, 2'd3, 30'h100, 32'hFFFF_0000, 4'hF, 1, "decerr_write");
  endtask
  task automatic test_back_to_back;
    set_slave(0, 0, 1'b0, 32'hAAAA_0000);
    set_slave(1, 1, 1'b0, 32'hBBBB_1111);
    do_txn(1'b0, 2'd0, 30'h8, 32'h0, 4'h0, 0, "b2b_0");
    do_txn(1'b0, 2'd1, 30'hC, 32'h0, 4'h0, 0, "b2b_1");
    do_txn(1'b1, 2'd0, 30'h8, 32'h0102_0304, 4'h9, 0, "b2b_2");
  endtask
  task automatic test_backpressure_reset;
    set_slave(1, 2, 1'b0, 32'h3C3C_3C3C);
    do_txn(1'b0, 2'd1, 30'h40, 32'h0, 4'h0, 5, "backpressure");
    set_slave(0, 10, 1'b0, 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0050; cmd_wdata = 32'h9999_9999; cmd_strb = 4'hF;
    @(negedge PCLK); cmd_valid = 1'b0;
    @(negedge PCLK); @(negedge PCLK);
    checks++; if (PENABLE !== 1'b1 || PSEL !== 3'b001) $display("FAIL mid_access: got psel %b en %b exp 001 1", PSEL, PENABLE); else passed++;
    #2 PRESETn = 1'b0;
    #1;
    checks++; if (PSEL !== 3'b0 || PENABLE !== 1'b0) $display("FAIL async_reset_drop: got psel %b en %b exp 0 0", PSEL, PENABLE); else passed++;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL async_reset_rsp: got valid %b ready %b exp 0 1", rsp_valid, cmd_ready); else passed++;
    @(negedge PCLK); PRESETn = 1'b1;
    @(negedge PCLK); @(negedge PCLK);
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 3'b0) $display("FAIL after_reset: got ready %b valid %b psel %b exp 1 0 000", cmd_ready, rsp_valid, PSEL); else passed++;
    set_slave(0, 0, 1'b0, 32'h0F0F_0F0F);
    do_txn(1'b0, 2'd0, 30'h54, 32'h0, 4'h0, 0, "recovery");
  endtask
  task automatic test_random;
    int waits [8] = '{0, 1, 2, 3, 4, TO - 1, TO, 25};
    int s;
    for (int n = 0; n < 30; n++) begin
      s = $urandom_range(0, 3);
      if (s < NS) set_slave(s, waits[$urandom_range(0, 7)], 1'($urandom_range(0, 3) == 0), $urandom);
      do_txn(1'($urandom), 2'(s), 30'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), "random");
    end
  endtask
  initial begin
    for (int k = 0; k < NS; k++) set_slave(k, 0, 1'b0, '0);
    test_reset;
    test_zero_wait_write;
    test_wait_read;
    test_slverr;
    test_timeout;
    test_decerr;
    test_back_to_back;
    test_backpressure_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
